// File: rtl/pio_pkg.sv
// pio_pkg: register map and edge-type encoding shared by the PIO family
package pio_pkg;
  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;
  typedef enum logic [1:0] {EDGE_RISE, EDGE_FALL, EDGE_ANY} edge_type_e;
endpackage

// File: rtl/pio_done_in_if.sv
// pio_done_in_if: Avalon-MM slave bus (address/chipselect/read_n/write_n/writedata in, readdata/irq out)
interface pio_done_in_if;
  logic [1:0] address;
  logic chipselect;
  logic read_n;
  logic write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic irq;
  modport master(output address, chipselect, read_n, write_n, writedata, input readdata, irq);
  modport slave(input address, chipselect, read_n, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/pio_sync_edge.sv
// pio_sync_edge: synchronises in_i over SYNC_STAGES flops (sync_o) and emits per-bit edge pulses (edge_o)
module pio_sync_edge import pio_pkg::*; #(
  parameter int WIDTH = 1,
  parameter int SYNC_STAGES = 2,
  parameter edge_type_e EDGE_TYPE = EDGE_RISE,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] edge_o
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
      prev_q <= RESET_VALUE;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  assign sync_o = sync_q[SYNC_STAGES-1];
  assign edge_o = EDGE_TYPE == EDGE_FALL ? ~sync_o & prev_q :
                  EDGE_TYPE == EDGE_ANY  ? sync_o ^ prev_q : sync_o & ~prev_q;
endmodule

// File: rtl/pio_done_in.sv
// pio_done_in: Avalon input PIO (clk, reset_n, in_port, bus) with sticky W1C edge capture and maskable level irq
module pio_done_in import pio_pkg::*; #(
  parameter int WIDTH = 1,
  parameter int EDGE_TYPE = 0,
  parameter int SYNC_STAGES = 2,
  parameter logic [31:0] RESET_VALUE = '0
) (
  input logic clk,
  input logic reset_n,
  input logic [WIDTH-1:0] in_port,
  pio_done_in_if.slave bus
);
  logic [WIDTH-1:0] s, pulse, w1c, mask_q, mask_d, edge_q, edge_d;
  logic [31:0] readdata_q, readdata_d;
  logic wr, rd;
  pio_sync_edge #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE(edge_type_e'(EDGE_TYPE)), .RESET_VALUE(RESET_VALUE[WIDTH-1:0])
  ) u_sync (.clk(clk), .reset_n(reset_n), .in_i(in_port), .sync_o(s), .edge_o(pulse));
  always_comb begin
    wr = bus.chipselect & ~bus.write_n;
    rd = bus.chipselect & ~bus.read_n;
    w1c = wr && bus.address == PIO_ADDR_EDGE ? bus.writedata[WIDTH-1:0] : '0;
    edge_d = (edge_q & ~w1c) | pulse;
    mask_d = wr && bus.address == PIO_ADDR_MASK ? bus.writedata[WIDTH-1:0] : mask_q;
    readdata_d = !rd ? readdata_q :
                 bus.address == PIO_ADDR_DATA ? 32'(s) :
                 bus.address == PIO_ADDR_MASK ? 32'(mask_q) :
                 bus.address == PIO_ADDR_EDGE ? 32'(edge_q) : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mask_q <= '0;
      edge_q <= '0;
      readdata_q <= '0;
    end else begin
      mask_q <= mask_d;
      edge_q <= edge_d;
      readdata_q <= readdata_d;
    end
  assign bus.readdata = readdata_q;
  assign bus.irq = |(edge_q & mask_q);
endmodule

// File: tb/tb_pio_done_in.sv
// tb_pio_done_in: directed vectors against a default rising-edge PIO and a 4-bit any-edge PIO
module tb_pio_done_in;
  import pio_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in0 = 1'b0;
  logic [3:0] in1 = 4'h0;
  logic [31:0] rv;
  int n_vec = 0;
  int n_bad = 0;
  pio_done_in_if b0();
  pio_done_in_if b1();
  pio_done_in u0 (.clk(clk), .reset_n(reset_n), .in_port(in0), .bus(b0));
  pio_done_in #(.WIDTH(4), .EDGE_TYPE(2)) u1 (.clk(clk), .reset_n(reset_n), .in_port(in1), .bus(b1));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drive(input int d, input logic rn, input logic wn, input logic [1:0] a, input logic [31:0] wd);
    if (d == 0) begin
      b0.chipselect = ~(rn & wn);
      b0.read_n = rn;
      b0.write_n = wn;
      b0.address = a;
      b0.writedata = wd;
    end else begin
      b1.chipselect = ~(rn & wn);
      b1.read_n = rn;
      b1.write_n = wn;
      b1.address = a;
      b1.writedata = wd;
    end
  endtask
  task automatic wr(input int d, input logic [1:0] a, input logic [31:0] wd);
    drive(d, 1'b1, 1'b0, a, wd);
    tick(1);
    drive(d, 1'b1, 1'b1, 2'd0, 32'h0);
  endtask
  task automatic rd(input int d, input logic [1:0] a, output logic [31:0] q);
    drive(d, 1'b0, 1'b1, a, 32'h0);
    tick(1);
    drive(d, 1'b1, 1'b1, 2'd0, 32'h0);
    q = d == 0 ? b0.readdata : b1.readdata;
  endtask
  initial begin
    drive(0, 1'b1, 1'b1, 2'd0, 32'h0);
    drive(1, 1'b1, 1'b1, 2'd0, 32'h0);
    tick(3);
    check("reset readdata0", b0.readdata, 32'h0);
    check("reset irq0", 32'(b0.irq), 32'h0);
    check("reset readdata1", b1.readdata, 32'h0);
    reset_n = 1'b1;
    tick(2);
    wr(0, PIO_ADDR_MASK, 32'h1);
    in0 = 1'b1;
    tick(2);
    check("irq before capture", 32'(b0.irq), 32'h0);
    tick(1);
    check("irq at capture", 32'(b0.irq), 32'h1);
    rd(0, PIO_ADDR_EDGE, rv);
    check("edge after rise", rv, 32'h1);
    wr(0, PIO_ADDR_EDGE, 32'h1);
    check("irq after w1c", 32'(b0.irq), 32'h0);
    tick(3);
    check("irq held high", 32'(b0.irq), 32'h0);
    rd(0, PIO_ADDR_EDGE, rv);
    check("edge held high", rv, 32'h0);
    rd(0, PIO_ADDR_DATA, rv);
    check("data high", rv, 32'h1);
    in0 = 1'b0;
    tick(3);
    check("falling ignored", 32'(b0.irq), 32'h0);
    in0 = 1'b1;
    tick(3);
    check("irq recapture", 32'(b0.irq), 32'h1);
    in0 = 1'b0;
    tick(3);
    in0 = 1'b1;
    tick(2);
    wr(0, PIO_ADDR_EDGE, 32'h1);
    check("collision irq", 32'(b0.irq), 32'h1);
    rd(0, PIO_ADDR_EDGE, rv);
    check("collision edge", rv, 32'h1);
    wr(0, PIO_ADDR_MASK, 32'h0);
    check("masked irq", 32'(b0.irq), 32'h0);
    rd(0, PIO_ADDR_EDGE, rv);
    check("masked edge kept", rv, 32'h1);
    rd(0, PIO_ADDR_MASK, rv);
    check("mask reads 0", rv, 32'h0);
    wr(0, PIO_ADDR_MASK, 32'h1);
    check("unmask irq", 32'(b0.irq), 32'h1);
    drive(0, 1'b0, 1'b0, PIO_ADDR_MASK, 32'h0);
    tick(1);
    drive(0, 1'b1, 1'b1, 2'd0, 32'h0);
    check("rd+wr old value", b0.readdata, 32'h1);
    check("rd+wr write done", 32'(b0.irq), 32'h0);
    wr(0, PIO_ADDR_MASK, 32'h1);
    wr(0, PIO_ADDR_EDGE, 32'h1);
    check("irq cleared", 32'(b0.irq), 32'h0);
    wr(1, PIO_ADDR_MASK, 32'hFFFF_FFFF);
    rd(1, PIO_ADDR_MASK, rv);
    check("w4 mask width", rv, 32'h0000_000F);
    in1 = 4'h4;
    tick(3);
    check("w4 irq up", 32'(b1.irq), 32'h1);
    rd(1, PIO_ADDR_EDGE, rv);
    check("w4 edge up", rv, 32'h4);
    rd(1, PIO_ADDR_DATA, rv);
    check("w4 data", rv, 32'h4);
    wr(1, PIO_ADDR_EDGE, 32'hFFFF_FFFF);
    check("w4 irq clear", 32'(b1.irq), 32'h0);
    wr(1, PIO_ADDR_DATA, 32'hFFFF_FFFF);
    wr(1, 2'd1, 32'hFFFF_FFFF);
    rd(1, PIO_ADDR_MASK, rv);
    check("w4 mask kept", rv, 32'h0000_000F);
    rd(1, PIO_ADDR_EDGE, rv);
    check("w4 edge kept", rv, 32'h0);
    rd(1, 2'd1, rv);
    check("w4 reserved", rv, 32'h0);
    rd(1, PIO_ADDR_DATA, rv);
    check("w4 data kept", rv, 32'h4);
    in1 = 4'h0;
    tick(3);
    check("w4 irq down", 32'(b1.irq), 32'h1);
    rd(1, PIO_ADDR_EDGE, rv);
    check("w4 edge down", rv, 32'h4);
    in0 = 1'b0;
    tick(3);
    in0 = 1'b1;
    tick(3);
    rd(0, PIO_ADDR_EDGE, rv);
    check("pre-reset edge", rv, 32'h1);
    reset_n = 1'b0;
    #1;
    check("async rst readdata", b0.readdata, 32'h0);
    check("async rst irq", 32'(b0.irq), 32'h0);
    tick(3);
    in0 = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(3);
    rd(0, PIO_ADDR_DATA, rv);
    check("post-rst data", rv, 32'h0);
    rd(0, PIO_ADDR_MASK, rv);
    check("post-rst mask", rv, 32'h0);
    rd(0, PIO_ADDR_EDGE, rv);
    check("post-rst edge", rv, 32'h0);
    check("post-rst irq", 32'(b0.irq), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pio_done_in.md
Name: pio_done_in

Overview:
- Avalon-MM slave input PIO that returns hardware status (e.g. "frame done" from the clean/filter pipeline) to the Nios CPU.
- Complements the CPU-driven start output PIO; sits on the same system interconnect.
- Synchronises the external input and captures edges in a sticky register.
- Raises a maskable level interrupt, so software can start a job and then wait on IRQ or poll.

Parameters:
- WIDTH, 1, number of input bits (1..32).
- EDGE_TYPE, 0, edge captured per bit: 0 = rising, 1 = falling, 2 = any.
- SYNC_STAGES, 2, synchroniser flops on in_port (2..3).
- RESET_VALUE, 0, reset value of the synchroniser flops and the previous-sample register.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  2  Avalon word address.
- chipselect  input  1  slave select.
- read_n  input  1  active-low read strobe.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- in_port  input  WIDTH  asynchronous status inputs from the datapath.
- readdata  output  32  registered read data, read latency 1.
- irq  output  1  level interrupt to CPU, active high.

Behaviour:
- Reset: sync chain = RESET_VALUE, prev = RESET_VALUE, irq_mask = 0, edge_capture = 0, readdata = 0; irq = 0.
- Clock: all state on posedge clk. Reset is asynchronous and may assert mid-operation; it clears pending edges immediately, and no capture occurs while reset_n = 0.
- Synchroniser: in_port passes through SYNC_STAGES flops, giving s. prev <= s every cycle.
- Edge detect, per bit i:
  - rising: s[i] & ~prev[i].
  - falling: ~s[i] & prev[i].
  - any: s[i] ^ prev[i].
- Latency: an in_port change is visible in edge_capture SYNC_STAGES+1 cycles later.
- Register map (wr = chipselect & ~write_n; rd = chipselect & ~read_n):
  - addr 0 DATA, RO: returns zero-extended s. Writes are ignored.
  - addr 1: reserved. Reads return 0; writes are ignored.
  - addr 2 IRQ_MASK, RW: writedata[WIDTH-1:0] is stored; upper bits are ignored.
  - addr 3 EDGE_CAPTURE, R/W1C: a bit is set on a detected edge and cleared by writing 1 to it. Writing 0 has no effect.
- Simultaneous W1C and new edge on the same bit in the same cycle: set wins, so the bit remains 1 and no event is lost.
- Reads: readdata <= selected register, zero-extended, on the cycle after rd is sampled. readdata holds its value when no read is in progress. Reads never have side effects; in particular, reading EDGE_CAPTURE does not clear it.
- Read and write in the same cycle: illegal on Avalon. Defined behaviour: the write takes effect, and the read returns the pre-write value.
- irq = |(edge_capture & irq_mask), combinational from registered state, with no extra latency.
- Level interrupt: irq stays asserted until software clears the captured bits or masks them.
- Mask behaviour: masking does not clear edge_capture. Unmasking a bit that is already captured asserts irq in the same cycle the mask register updates.
- A held-high input produces exactly one capture for rising-edge type. Repeated edges while a bit is already set are absorbed, with no counting.
- Width rule: all unused readdata bits [31:WIDTH] are 0.

Decomposition:
- Shared package pio_pkg holds:
  - address constants: PIO_ADDR_DATA = 0, PIO_ADDR_MASK = 2, PIO_ADDR_EDGE = 3.
  - edge-type enum: EDGE_RISE, EDGE_FALL, EDGE_ANY.
- pio_pkg is shared with the output PIO and future PIOs.
- One natural sub-module: pio_sync_edge. It is parameterised WIDTH/SYNC_STAGES/EDGE_TYPE and contains the synchroniser, the prev register and the edge-pulse output. The Avalon register file stays in the top level.

Test Plan:
- Reset check: assert reset_n = 0 mid-run with in_port = 1 → readdata = 0, irq = 0, and all three readable registers read 0 after release, assuming in_port = 0 at release.
- Rising edge with IRQ: write MASK = 0x1; drive in_port 0→1 → EDGE_CAPTURE bit0 = 1 exactly 3 cycles after the change with default SYNC_STAGES; irq = 1; read addr 3 returns 0x00000001 one cycle after the read strobe.
- W1C clear: write 0x1 to addr 3 → irq = 0 the next cycle; in_port held high produces no re-capture; read addr 0 returns 0x1.
- Clear/edge collision: time the W1C write to the same cycle a new rising edge is detected → bit0 stays 1 and irq stays 1.
- Masking: MASK = 0 with a captured edge → irq = 0 while EDGE_CAPTURE reads 0x1; then write MASK = 0x1 → irq = 1 in the cycle after the write.
- WIDTH = 4, EDGE_TYPE = any: toggle bit2 up then down, with a clear in between → two separate captures of 0x4; bits [31:4] always read 0; writes to addr 0 and addr 1 leave all state unchanged.
